// File: rtl/sad_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sad_accumulator_pkg
// Purpose : Shared types, default constants and width helpers for the SAD
//           accumulator and its row adder tree.
// Contents: state_t FSM encoding, DEF_* defaults, ROW_LANES, sad_width(),
//           cand_width().
// Revision: 1.0 - initial release
// ============================================================================
package sad_accumulator_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_ROWS      = 8;
  localparam int DEF_NUM_CAND  = 9;

  // Absolute differences delivered per row.
  localparam int ROW_LANES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Wide enough for ROW_LANES*rows maximal differences, so the sum never wraps.
  function automatic int sad_width(input int datawidth, input int rows);
    return datawidth + $clog2(ROW_LANES * rows);
  endfunction

  function automatic int cand_width(input int num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/absdiff_row_sum.sv
`default_nettype none
// ============================================================================
// Module  : absdiff_row_sum
// Purpose : Combinational three-level adder tree summing one row of eight
//           absolute differences; each level widens by one bit.
// Ports   : absdiff[8] - row inputs, DATAWIDTH bits each
//           row_sum    - zero-extended row total, DATAWIDTH+3 bits
// Revision: 1.0 - initial release
// ============================================================================
module absdiff_row_sum
  import sad_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] absdiff [ROW_LANES],
  output logic [DATAWIDTH+2:0] row_sum
);

  logic [DATAWIDTH:0]   lvl1 [4];
  logic [DATAWIDTH+1:0] lvl2 [2];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lvl1
      assign lvl1[i] = {1'b0, absdiff[2*i]} + {1'b0, absdiff[2*i+1]};
    end
    for (genvar j = 0; j < 2; j++) begin : g_lvl2
      assign lvl2[j] = {1'b0, lvl1[2*j]} + {1'b0, lvl1[2*j+1]};
    end
  endgenerate

  assign row_sum = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};

endmodule
`default_nettype wire

// File: rtl/sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : sad_accumulator
// Purpose : Accumulates ROWS rows of eight absolute differences into one SAD
//           per candidate, over NUM_CAND candidates, and reports the minimum
//           SAD and its index at the end of each search.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           start           - pulse in IDLE to begin a search
//           in_valid/ready  - row handshake; ready only while accumulating
//           absdiff_0..7    - one row of absolute differences
//           sad_valid, sad  - per-candidate SAD pulse and value
//           best_valid      - pulse at search end
//           best_sad/idx    - minimum SAD and its candidate index
//           busy            - high whenever not IDLE
// Revision: 1.0 - initial release
// ============================================================================
module sad_accumulator
  import sad_accumulator_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ROWS      = DEF_ROWS,
  parameter int NUM_CAND  = DEF_NUM_CAND
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATAWIDTH-1:0]                   absdiff_0,
  input  logic [DATAWIDTH-1:0]                   absdiff_1,
  input  logic [DATAWIDTH-1:0]                   absdiff_2,
  input  logic [DATAWIDTH-1:0]                   absdiff_3,
  input  logic [DATAWIDTH-1:0]                   absdiff_4,
  input  logic [DATAWIDTH-1:0]                   absdiff_5,
  input  logic [DATAWIDTH-1:0]                   absdiff_6,
  input  logic [DATAWIDTH-1:0]                   absdiff_7,
  output logic                                   sad_valid,
  output logic [sad_width(DATAWIDTH, ROWS)-1:0]  sad,
  output logic                                   best_valid,
  output logic [sad_width(DATAWIDTH, ROWS)-1:0]  best_sad,
  output logic [cand_width(NUM_CAND)-1:0]        best_idx,
  output logic                                   busy
);

  localparam int SADW  = sad_width(DATAWIDTH, ROWS);
  localparam int CANDW = cand_width(NUM_CAND);
  localparam int ROWW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RSW   = DATAWIDTH + 3;

  state_t               state;
  logic [ROWW-1:0]      row_cnt;
  logic [CANDW-1:0]     cand_cnt;
  logic [SADW-1:0]      acc;
  logic [DATAWIDTH-1:0] row_in [ROW_LANES];
  logic [RSW-1:0]       row_sum;
  logic [SADW-1:0]      acc_next;

  assign row_in[0] = absdiff_0;
  assign row_in[1] = absdiff_1;
  assign row_in[2] = absdiff_2;
  assign row_in[3] = absdiff_3;
  assign row_in[4] = absdiff_4;
  assign row_in[5] = absdiff_5;
  assign row_in[6] = absdiff_6;
  assign row_in[7] = absdiff_7;

  absdiff_row_sum #(
    .DATAWIDTH (DATAWIDTH)
  ) u_row_sum (
    .absdiff (row_in),
    .row_sum (row_sum)
  );

  assign acc_next = acc + SADW'(row_sum);

  // Handshake and busy are pure decodes of the registered state.
  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      cand_cnt   <= '0;
      acc        <= '0;
      sad        <= '0;
      sad_valid  <= 1'b0;
      best_valid <= 1'b0;
      best_sad   <= '1;
      best_idx   <= '0;
    end else begin
      sad_valid  <= 1'b0;
      best_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
            acc      <= '0;
            best_sad <= '1;
            best_idx <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (row_cnt == ROWW'(ROWS - 1)) begin
              // Last row: publish the SAD now so sad_valid lines up with REPORT.
              sad       <= acc_next;
              acc       <= '0;
              row_cnt   <= '0;
              sad_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              acc     <= acc_next;
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          // Strict compare: on ties the earlier (lower) index is retained.
          if (sad < best_sad) begin
            best_sad <= sad;
            best_idx <= cand_cnt;
          end
          if (cand_cnt == CANDW'(NUM_CAND - 1)) begin
            best_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            cand_cnt <= cand_cnt + 1'b1;
            state    <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_sad_accumulator
// Purpose : Scoreboard bench for sad_accumulator. The driver builds each
//           search's data, computes expected SADs and the best candidate with
//           plain arithmetic and queues them; a negedge monitor pops and
//           compares on every sad_valid / best_valid pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sad_accumulator;

  localparam int DW    = 8;
  localparam int ROWS  = 8;
  localparam int NC    = 9;
  localparam int SADW  = 14;
  localparam int CANDW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    ad [8];
  logic             sad_valid;
  logic [SADW-1:0]  sad;
  logic             best_valid;
  logic [SADW-1:0]  best_sad;
  logic [CANDW-1:0] best_idx;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int unsigned data [NC][ROWS][8];
  int unsigned sad_q[$];
  int unsigned best_sad_q[$];
  int unsigned best_idx_q[$];

  int sad_seen;
  int first_sad_cyc;
  int best_cyc;
  int unsigned last_best_sad;
  int unsigned last_best_idx;

  sad_accumulator #(
    .DATAWIDTH (DW),
    .ROWS      (ROWS),
    .NUM_CAND  (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .absdiff_0  (ad[0]),
    .absdiff_1  (ad[1]),
    .absdiff_2  (ad[2]),
    .absdiff_3  (ad[3]),
    .absdiff_4  (ad[4]),
    .absdiff_5  (ad[5]),
    .absdiff_6  (ad[6]),
    .absdiff_7  (ad[7]),
    .sad_valid  (sad_valid),
    .sad        (sad),
    .best_valid (best_valid),
    .best_sad   (best_sad),
    .best_idx   (best_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      // Rows are taken only while accumulating; REPORT is the sad_valid cycle.
      chk("in_ready_state", in_ready, busy && !sad_valid);
      if (sad_valid) begin
        if (sad_seen == 0) first_sad_cyc = cyc;
        sad_seen++;
        if (sad_q.size() == 0) chk("unexpected_sad_valid", 1, 0);
        else chk("sad", sad, sad_q.pop_front());
      end
      if (best_valid) begin
        best_cyc = cyc;
        chk("busy_at_best_valid", busy, 0);
        if (best_sad_q.size() == 0) chk("unexpected_best_valid", 1, 0);
        else begin
          chk("best_sad", best_sad, best_sad_q.pop_front());
          chk("best_idx", best_idx, best_idx_q.pop_front());
        end
      end
    end
  end

  // pattern: 0 random, 1 all 255, 2 value 10-k, 3 all 5, 4 random 0..1, 5 keep
  task automatic fill(input int pattern);
    if (pattern == 5) return;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < ROWS; r++)
        for (int l = 0; l < 8; l++)
          case (pattern)
            1:       data[c][r][l] = 255;
            2:       data[c][r][l] = 10 - c;
            3:       data[c][r][l] = 5;
            4:       data[c][r][l] = $urandom_range(0, 1);
            default: data[c][r][l] = $urandom_range(0, 255);
          endcase
  endtask

  // Reference: per-candidate plain sums, strict minimum keeps the first index.
  task automatic push_expected(input int upto_cand, input bit with_best);
    int unsigned bs;
    int unsigned bi;
    bs = 32'hFFFF_FFFF;
    bi = 0;
    for (int c = 0; c < upto_cand; c++) begin
      int unsigned s;
      s = 0;
      for (int r = 0; r < ROWS; r++)
        for (int l = 0; l < 8; l++) s += data[c][r][l];
      sad_q.push_back(s);
      if (s < bs) begin
        bs = s;
        bi = c;
      end
    end
    if (with_best) begin
      best_sad_q.push_back(bs);
      best_idx_q.push_back(bi);
      last_best_sad = bs;
      last_best_idx = bi;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_sad_valid"}, sad_valid, 0);
    chk({tag, "_best_valid"}, best_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sad"}, sad, 0);
    chk({tag, "_best_sad"}, best_sad, 16383);
    chk({tag, "_best_idx"}, best_idx, 0);
  endtask

  task automatic run_search(input int pattern, input bit toggle, input bit abort,
                            input bit extra_start);
    int first_acc_cyc;
    int start_cyc;
    bit phase;
    fill(pattern);
    if (abort) push_expected(4, 1'b0);
    else push_expected(NC, 1'b1);
    sad_seen      = 0;
    first_acc_cyc = 0;
    phase         = 1'b1;
    in_valid      = 1'b0;
    start         = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        bit accepted;
        int tries;
        accepted = 1'b0;
        tries    = 0;
        while (!accepted) begin
          if (abort && c == 4 && r == 3) begin
            rst = 1'b1;
            #1;
            check_reset_values("mid_reset");
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            sad_q.delete();
            repeat (12) @(posedge clk);
            #1;
            check_reset_values("after_abort");
            return;
          end
          in_valid = toggle ? phase : 1'b1;
          phase    = ~phase;
          for (int l = 0; l < 8; l++)
            ad[l] = in_valid ? DW'(data[c][r][l]) : DW'($urandom_range(0, 255));
          if (extra_start && c == 1 && r == 2) start = 1'b1;
          @(negedge clk);
          if (in_valid && in_ready) begin
            accepted = 1'b1;
            if (c == 0 && r == 0) first_acc_cyc = cyc;
          end
          @(posedge clk); #1;
          start = 1'b0;
          tries++;
          if (tries > 10) begin
            chk("row_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (sad_q.size() + best_sad_q.size()) != 0; i++)
      @(posedge clk);
    #1;
    chk("search_complete_pending", sad_q.size() + best_sad_q.size(), 0);
    if (!toggle) begin
      chk("first_sad_latency", first_sad_cyc - first_acc_cyc, ROWS);
      chk("search_cycles", best_cyc - start_cyc, NC * (ROWS + 1) + 1);
    end
    chk("sad_pulse_count", sad_seen, NC);
    // Best results must persist in IDLE.
    repeat (5) @(posedge clk);
    #1;
    chk("best_sad_hold", best_sad, last_best_sad);
    chk("best_idx_hold", best_idx, last_best_idx);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int l = 0; l < 8; l++) ad[l] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_search(1, 1'b0, 1'b0, 1'b0);   // all 255 -> 16320 each, idx 0
    run_search(2, 1'b0, 1'b0, 1'b0);   // 10-k -> best idx 8, sad 128
    run_search(3, 1'b0, 1'b0, 1'b0);   // ties -> idx 0, sad 320
    run_search(0, 1'b0, 1'b0, 1'b0);   // random, continuous
    run_search(5, 1'b1, 1'b0, 1'b0);   // same data, in_valid toggling
    run_search(0, 1'b0, 1'b1, 1'b0);   // reset at candidate 4, row 3
    run_search(0, 1'b0, 1'b0, 1'b0);   // fresh search after abort
    run_search(2, 1'b0, 1'b0, 1'b1);   // start pulsed during ACCUM
    for (int i = 0; i < 3; i++)
      run_search(4, 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
